// File: rtl/serv_csr_pkg.sv
// Shared constants for the SERV machine-mode CSR / interrupt unit.
package serv_csr_pkg;

  // i_csr_source encodings
  localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
  localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;
  localparam logic [1:0] CSR_SOURCE_SET = 2'b10;
  localparam logic [1:0] CSR_SOURCE_CLR = 2'b11;

  // Interrupt cause codes
  localparam logic [4:0] MCAUSE_MSI       = 5'd3;
  localparam logic [4:0] MCAUSE_MTI       = 5'd7;
  localparam logic [4:0] MCAUSE_MEI       = 5'd11;
  localparam logic [4:0] MCAUSE_PIRQ_BASE = 5'd16;

  // Exception cause codes
  localparam logic [4:0] EXC_JUMP_MISALIGN  = 5'd0;
  localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ECALL_M        = 5'd11;

  // Bit positions inside the 32-bit CSR views
  localparam int unsigned BIT_MIE       = 3;
  localparam int unsigned BIT_MPIE      = 7;
  localparam int unsigned BIT_MPP_LO    = 11;
  localparam int unsigned BIT_MPP_HI    = 12;
  localparam int unsigned BIT_MSI       = 3;
  localparam int unsigned BIT_MTI       = 7;
  localparam int unsigned BIT_MEI       = 11;
  localparam int unsigned BIT_PIRQ_BASE = 16;
  localparam int unsigned BIT_INTR      = 31;

  // Exception class decode, same priority as the existing decoder outputs.
  function automatic logic [4:0] exc_code(input logic e_op, input logic ebreak,
                                          input logic mem_op, input logic mem_cmd);
    if (e_op) begin
      return ebreak ? EXC_BREAKPOINT : EXC_ECALL_M;
    end else if (mem_op) begin
      return mem_cmd ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
    end else begin
      return EXC_JUMP_MISALIGN;
    end
  endfunction

endpackage

// File: rtl/serv_irq_arb.sv
// Fixed-priority interrupt arbiter: MEI > MSI > MTI > PIRQ[0] .. PIRQ[N-1].
module serv_irq_arb
  import serv_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  localparam int unsigned PW = (NUM_IRQ > 0) ? NUM_IRQ : 1
) (
  input  logic          meip,
  input  logic          msip,
  input  logic          mtip,
  input  logic [PW-1:0] pirq,
  input  logic          meie,
  input  logic          msie,
  input  logic          mtie,
  input  logic [PW-1:0] pie,
  output logic          valid,
  output logic [4:0]    code
);

  logic       pirq_hit;
  logic [4:0] pirq_code;

  // Lowest-numbered eligible platform line wins among the platform interrupts.
  always_comb begin
    pirq_hit  = 1'b0;
    pirq_code = '0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      if (!pirq_hit && pirq[k] && pie[k]) begin
        pirq_hit  = 1'b1;
        pirq_code = MCAUSE_PIRQ_BASE + 5'(k);
      end
    end
  end

  // Priority select between standard and platform sources.
  always_comb begin
    valid = 1'b1;
    code  = MCAUSE_MEI;
    if (meip && meie) begin
      code = MCAUSE_MEI;
    end else if (msip && msie) begin
      code = MCAUSE_MSI;
    end else if (mtip && mtie) begin
      code = MCAUSE_MTI;
    end else if (pirq_hit) begin
      code = pirq_code;
    end else begin
      valid = 1'b0;
      code  = '0;
    end
  end

endmodule

// File: rtl/serv_csr_irqx.sv
// Machine-mode CSR and interrupt unit for SERV, streaming W bits per cycle LSB-first.
module serv_csr_irqx
  import serv_csr_pkg::*;
#(
  parameter int unsigned W              = 1,
  parameter int unsigned NUM_IRQ        = 4,
  parameter string       RESET_STRATEGY = "MINI",
  localparam int unsigned PW = (NUM_IRQ > 0) ? NUM_IRQ : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [4:0]    i_pos,
  input  logic          i_cnt_done,
  input  logic          i_trig_irq,
  input  logic          i_mtip,
  input  logic          i_msip,
  input  logic          i_meip,
  input  logic [PW-1:0] i_pirq,
  input  logic          i_trap,
  input  logic          i_mret,
  input  logic          i_e_op,
  input  logic          i_ebreak,
  input  logic          i_mem_op,
  input  logic          i_mem_cmd,
  input  logic          i_mstatus_en,
  input  logic          i_mie_en,
  input  logic          i_mip_en,
  input  logic          i_mcause_en,
  input  logic [1:0]    i_csr_source,
  input  logic          i_csr_d_sel,
  input  logic [W-1:0]  i_csr_imm,
  input  logic [W-1:0]  i_rs1,
  input  logic [W-1:0]  i_rf_csr_out,
  output logic [W-1:0]  o_q,
  output logic [W-1:0]  o_csr_in,
  output logic          o_new_irq
);

  localparam bit DoReset = (RESET_STRATEGY != "NONE");

  logic          rst;
  logic          trap_done;
  logic          mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic          mie_msie_q, mie_msie_d, mie_mtie_q, mie_mtie_d, mie_meie_q, mie_meie_d;
  logic [PW-1:0] mie_pie_q, mie_pie_d;
  logic [4:0]    mcause_code_q, mcause_code_d;
  logic          mcause_intr_q, mcause_intr_d;
  logic          irq_r_q, irq_r_d, new_irq_q, new_irq_d;
  logic [4:0]    irq_code_q, irq_code_d;
  logic          arb_valid, irq;
  logic [4:0]    arb_code;
  logic [31:0]   mstatus_view, mie_view, mip_view, mcause_view, csr_view;
  logic [31:0]   wr_val, wr_mask;
  logic [W-1:0]  q, d, csr_in;
  logic          unused_wr;

  assign rst       = DoReset && i_rst;
  assign trap_done = i_trap && i_cnt_done;
  assign irq       = arb_valid && mstatus_mie_q;
  assign o_q       = q;
  assign o_csr_in  = csr_in;
  assign o_new_irq = new_irq_q;
  // Only a few positions of the write word land in registers.
  assign unused_wr = ^{wr_val, wr_mask};

  serv_irq_arb #(
    .NUM_IRQ(NUM_IRQ)
  ) u_arb (
    .meip (i_meip),
    .msip (i_msip),
    .mtip (i_mtip),
    .pirq (i_pirq),
    .meie (mie_meie_q),
    .msie (mie_msie_q),
    .mtie (mie_mtie_q),
    .pie  (mie_pie_q),
    .valid(arb_valid),
    .code (arb_code)
  );

  // Build 32-bit virtual CSR views, pick the selected one and extract the current slice.
  always_comb begin
    mstatus_view                        = '0;
    mstatus_view[BIT_MIE]               = mstatus_mie_q;
    mstatus_view[BIT_MPIE]              = mstatus_mpie_q;
    mstatus_view[BIT_MPP_HI:BIT_MPP_LO] = 2'b11;
    mie_view          = '0;
    mie_view[BIT_MSI] = mie_msie_q;
    mie_view[BIT_MTI] = mie_mtie_q;
    mie_view[BIT_MEI] = mie_meie_q;
    mip_view          = '0;
    mip_view[BIT_MSI] = i_msip;
    mip_view[BIT_MTI] = i_mtip;
    mip_view[BIT_MEI] = i_meip;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      mie_view[BIT_PIRQ_BASE+k] = mie_pie_q[k];
      mip_view[BIT_PIRQ_BASE+k] = i_pirq[k];
    end
    mcause_view = {mcause_intr_q, 26'd0, mcause_code_q};
    csr_view = ({32{i_mstatus_en}} & mstatus_view) | ({32{i_mie_en}} & mie_view) |
               ({32{i_mip_en}} & mip_view) | ({32{i_mcause_en}} & mcause_view);
    q = csr_view[i_pos +: W] | i_rf_csr_out;
    d = i_csr_d_sel ? i_csr_imm : i_rs1;
    unique case (i_csr_source)
      CSR_SOURCE_EXT: csr_in = d;
      CSR_SOURCE_SET: csr_in = q | d;
      CSR_SOURCE_CLR: csr_in = q & ~d;
      CSR_SOURCE_CSR: csr_in = q;
    endcase
    wr_val  = 32'(csr_in) << i_pos;
    wr_mask = 32'({W{1'b1}}) << i_pos;
  end

  // Next state: CSR slice writes first, then trap/mret/trigger override.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_msie_d     = mie_msie_q;
    mie_mtie_d     = mie_mtie_q;
    mie_meie_d     = mie_meie_q;
    mie_pie_d      = mie_pie_q;
    mcause_code_d  = mcause_code_q;
    mcause_intr_d  = mcause_intr_q;
    irq_r_d        = irq_r_q;
    new_irq_d      = new_irq_q;
    irq_code_d     = irq_code_q;

    if (i_en && i_mstatus_en) begin
      if (wr_mask[BIT_MIE])  mstatus_mie_d  = wr_val[BIT_MIE];
      if (wr_mask[BIT_MPIE]) mstatus_mpie_d = wr_val[BIT_MPIE];
    end
    if (i_en && i_mie_en) begin
      if (wr_mask[BIT_MSI]) mie_msie_d = wr_val[BIT_MSI];
      if (wr_mask[BIT_MTI]) mie_mtie_d = wr_val[BIT_MTI];
      if (wr_mask[BIT_MEI]) mie_meie_d = wr_val[BIT_MEI];
      for (int k = 0; k < int'(NUM_IRQ); k++) begin
        if (wr_mask[BIT_PIRQ_BASE+k]) mie_pie_d[k] = wr_val[BIT_PIRQ_BASE+k];
      end
    end
    if (i_en && i_mcause_en) begin
      for (int b = 0; b < 5; b++) begin
        if (wr_mask[b]) mcause_code_d[b] = wr_val[b];
      end
      if (wr_mask[BIT_INTR]) mcause_intr_d = wr_val[BIT_INTR];
    end

    if (trap_done) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mcause_intr_d  = new_irq_q;
      mcause_code_d  = new_irq_q ? irq_code_q : exc_code(i_e_op, i_ebreak, i_mem_op, i_mem_cmd);
    end else if (i_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    // Edge-detect so a held level produces a single new_irq.
    if (i_trig_irq) begin
      irq_r_d    = irq;
      new_irq_d  = irq && !irq_r_q;
      irq_code_d = arb_code;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_msie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_pie_q      <= '0;
      irq_r_q        <= 1'b0;
      new_irq_q      <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_msie_q     <= mie_msie_d;
      mie_mtie_q     <= mie_mtie_d;
      mie_meie_q     <= mie_meie_d;
      mie_pie_q      <= mie_pie_d;
      irq_r_q        <= irq_r_d;
      new_irq_q      <= new_irq_d;
    end
  end

  // Cause state, never reset.
  always_ff @(posedge i_clk) begin
    mcause_code_q <= mcause_code_d;
    mcause_intr_q <= mcause_intr_d;
    irq_code_q    <= irq_code_d;
  end

endmodule

// File: tb/tb_serv_csr_irqx.sv
// Scoreboard bench for serv_csr_irqx: W=4 main instance plus a W=1 instance.
module tb_serv_csr_irqx;
  import serv_csr_pkg::*;

  localparam int unsigned NumIrq = 4;
  localparam logic [3:0] SelMstatus = 4'b0001;
  localparam logic [3:0] SelMie     = 4'b0010;
  localparam logic [3:0] SelMip     = 4'b0100;
  localparam logic [3:0] SelMcause  = 4'b1000;

  logic clk = 1'b0;
  logic rst, trig, mtip, msip, meip, trap, mret, e_op, ebreak, mem_op, mem_cmd;
  logic [NumIrq-1:0] pirq;
  logic mstatus_en, mie_en, mip_en, mcause_en;
  logic [1:0] source;
  logic en4, done4, en1, done1;
  logic [4:0] pos4, pos1;
  logic [3:0] rs1_4, q4, unused_csr_in4;
  logic rs1_1, q1, unused_csr_in1, new_irq4, unused_new_irq1;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon4 = 1'b0, mon1 = 1'b0, obs_irq = 1'b0;
  logic [31:0] acc4 = '0, acc1 = '0;

  always #5 clk = ~clk;

  serv_csr_irqx #(.W(4), .NUM_IRQ(NumIrq), .RESET_STRATEGY("MINI")) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en4), .i_pos(pos4), .i_cnt_done(done4),
    .i_trig_irq(trig), .i_mtip(mtip), .i_msip(msip), .i_meip(meip), .i_pirq(pirq),
    .i_trap(trap), .i_mret(mret), .i_e_op(e_op), .i_ebreak(ebreak), .i_mem_op(mem_op),
    .i_mem_cmd(mem_cmd), .i_mstatus_en(mstatus_en), .i_mie_en(mie_en), .i_mip_en(mip_en),
    .i_mcause_en(mcause_en), .i_csr_source(source), .i_csr_d_sel(1'b0), .i_csr_imm(4'd0),
    .i_rs1(rs1_4), .i_rf_csr_out(4'd0), .o_q(q4), .o_csr_in(unused_csr_in4),
    .o_new_irq(new_irq4)
  );

  serv_csr_irqx #(.W(1), .NUM_IRQ(NumIrq), .RESET_STRATEGY("MINI")) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_pos(pos1), .i_cnt_done(done1),
    .i_trig_irq(trig), .i_mtip(mtip), .i_msip(msip), .i_meip(meip), .i_pirq(pirq),
    .i_trap(trap), .i_mret(mret), .i_e_op(e_op), .i_ebreak(ebreak), .i_mem_op(mem_op),
    .i_mem_cmd(mem_cmd), .i_mstatus_en(mstatus_en), .i_mie_en(mie_en), .i_mip_en(mip_en),
    .i_mcause_en(mcause_en), .i_csr_source(source), .i_csr_d_sel(1'b0), .i_csr_imm(1'b0),
    .i_rs1(rs1_1), .i_rf_csr_out(1'b0), .o_q(q1), .o_csr_in(unused_csr_in1),
    .o_new_irq(unused_new_irq1)
  );

  task automatic check_word(input logic [31:0] got);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output: got=%h required=<none queued>", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s: got=%h required=%h", e.name, got, e.val);
      end
    end
  endtask

  // Monitor: assemble streamed words and sample new_irq probes, compare with queue head.
  always @(negedge clk) begin
    if (mon4 && en4) begin
      acc4 = acc4 | (32'(q4) << pos4);
      if (done4) begin
        check_word(acc4);
        acc4 = '0;
      end
    end
    if (mon1 && en1) begin
      acc1 = acc1 | (32'(q1) << pos1);
      if (done1) begin
        check_word(acc1);
        acc1 = '0;
      end
    end
    if (obs_irq) check_word({31'd0, new_irq4});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic csr_op(input bit wide, input logic [3:0] sel, input logic [1:0] src,
                        input logic [31:0] d, input bit chk, input logic [31:0] exp_ret,
                        input string name);
    if (chk) push_exp(name, exp_ret);
    {mcause_en, mip_en, mie_en, mstatus_en} = sel;
    source = src;
    mon4 = chk && wide;
    mon1 = chk && !wide;
    if (wide) begin
      for (int i = 0; i < 8; i++) begin
        en4 = 1'b1; pos4 = 5'(i * 4); done4 = (i == 7); rs1_4 = d[i*4 +: 4];
        cycle();
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        en1 = 1'b1; pos1 = 5'(i); done1 = (i == 31); rs1_1 = d[i];
        cycle();
      end
    end
    en4 = 1'b0; done4 = 1'b0; en1 = 1'b0; done1 = 1'b0;
    {mcause_en, mip_en, mie_en, mstatus_en} = 4'b0000;
    mon4 = 1'b0; mon1 = 1'b0;
  endtask

  task automatic rd(input logic [3:0] sel, input logic [31:0] exp_val, input string name);
    csr_op(1'b1, sel, CSR_SOURCE_SET, 32'd0, 1'b1, exp_val, name);
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    cycle();
    trig = 1'b0;
  endtask

  task automatic probe(input logic exp_val, input string name);
    push_exp(name, {31'd0, exp_val});
    obs_irq = 1'b1;
    cycle();
    obs_irq = 1'b0;
  endtask

  task automatic trap_pulse(input logic eo, input logic eb, input logic mo, input logic mc,
                            input logic with_mret);
    e_op = eo; ebreak = eb; mem_op = mo; mem_cmd = mc; mret = with_mret;
    trap = 1'b1; done4 = 1'b1;
    cycle();
    trap = 1'b0; done4 = 1'b0; mret = 1'b0;
    e_op = 1'b0; ebreak = 1'b0; mem_op = 1'b0; mem_cmd = 1'b0;
  endtask

  task automatic mret_pulse();
    mret = 1'b1;
    cycle();
    mret = 1'b0;
  endtask

  // Clear irq_r with MIE=0, enable MIE, trigger, trap, then read mcause.
  task automatic arb_round(input logic [4:0] code, input string name);
    trig_pulse();
    csr_op(1'b1, SelMstatus, CSR_SOURCE_SET, 32'h8, 1'b0, 32'd0, "");
    trig_pulse();
    probe(1'b1, {name, "_new_irq"});
    trap_pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(SelMcause, 32'h8000_0000 | 32'(code), {name, "_mcause"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trig = 1'b0; mtip = 1'b0; msip = 1'b0; meip = 1'b0; pirq = '0;
    trap = 1'b0; mret = 1'b0; e_op = 1'b0; ebreak = 1'b0; mem_op = 1'b0; mem_cmd = 1'b0;
    mstatus_en = 1'b0; mie_en = 1'b0; mip_en = 1'b0; mcause_en = 1'b0;
    source = CSR_SOURCE_CSR; en4 = 1'b0; done4 = 1'b0; pos4 = '0; rs1_4 = '0;
    en1 = 1'b0; done1 = 1'b0; pos1 = '0; rs1_1 = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;

    probe(1'b0, "reset_new_irq");
    rd(SelMstatus, 32'h0000_1800, "mstatus_w4_reset");
    csr_op(1'b0, SelMstatus, CSR_SOURCE_SET, 32'd0, 1'b1, 32'h0000_1800, "mstatus_w1_reset");
    rd(SelMie, 32'h0, "mie_reset");

    // Timer interrupt path
    csr_op(1'b1, SelMie, CSR_SOURCE_SET, 32'h888, 1'b1, 32'h0, "csrrs_mie_old");
    rd(SelMie, 32'h888, "mie_after_set");
    csr_op(1'b1, SelMstatus, CSR_SOURCE_SET, 32'h8, 1'b1, 32'h1800, "csrrs_mstatus_old");
    rd(SelMstatus, 32'h1808, "mstatus_mie_set");
    mtip = 1'b1;
    trig_pulse();
    probe(1'b1, "mti_new_irq");
    trap_pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(SelMcause, 32'h8000_0007, "mcause_mti");
    rd(SelMstatus, 32'h1880, "mstatus_after_irq_trap");
    mtip = 1'b0;

    // Priority arbitration
    csr_op(1'b1, SelMie, CSR_SOURCE_SET, 32'h1_0000, 1'b1, 32'h888, "csrrs_mie_pie0_old");
    meip = 1'b1; msip = 1'b1; pirq = 4'b0001;
    arb_round(5'd11, "arb_mei");
    meip = 1'b0;
    arb_round(5'd3, "arb_msi");
    msip = 1'b0;
    arb_round(5'd16, "arb_pirq0");

    // Held level pulses once
    trig_pulse();
    csr_op(1'b1, SelMstatus, CSR_SOURCE_SET, 32'h8, 1'b0, 32'd0, "");
    trig_pulse();
    probe(1'b1, "level_first_trig");
    trig_pulse();
    probe(1'b0, "level_second_trig");
    pirq = '0;

    // ecall trap then mret
    trap_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(SelMcause, 32'h0000_000B, "mcause_ecall");
    rd(SelMstatus, 32'h1880, "mstatus_after_ecall");
    mret_pulse();
    rd(SelMstatus, 32'h1888, "mstatus_after_mret");

    // Trap wins over simultaneous mret
    trap_pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rd(SelMcause, 32'h0000_0003, "mcause_ebreak");
    rd(SelMstatus, 32'h1880, "mstatus_trap_beats_mret");
    mret_pulse();

    // Store misalign
    trap_pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rd(SelMcause, 32'h0000_0006, "mcause_store_misalign");
    mret_pulse();

    // mip is read-only and live
    pirq = 4'b0010;
    csr_op(1'b1, SelMip, CSR_SOURCE_EXT, 32'hFFFF_FFFF, 1'b1, 32'h0002_0000, "csrrw_mip_old");
    rd(SelMip, 32'h0002_0000, "mip_readback");
    pirq = '0;

    // Reset during a csrrw mie stream
    mie_en = 1'b1; source = CSR_SOURCE_EXT;
    for (int i = 0; i < 5; i++) begin
      en4 = 1'b1; pos4 = 5'(i * 4); done4 = 1'b0; rs1_4 = 4'hF; rst = (i == 4);
      cycle();
    end
    en4 = 1'b0; mie_en = 1'b0; rst = 1'b0;
    rd(SelMie, 32'h0, "mie_after_mid_reset");
    rd(SelMstatus, 32'h1800, "mstatus_after_mid_reset");
    probe(1'b0, "new_irq_after_mid_reset");

    // Clear operation
    csr_op(1'b1, SelMie, CSR_SOURCE_SET, 32'h808, 1'b1, 32'h0, "csrrs_mie_again_old");
    csr_op(1'b1, SelMie, CSR_SOURCE_CLR, 32'h8, 1'b1, 32'h808, "csrrc_mie_old");
    rd(SelMie, 32'h800, "mie_after_clr");

    cycle();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
